// File: rtl/get_bit.sv
// get_bit: MSB-first bit-stream field extractor with a 64-bit buffer, byte-wise fill and byte alignment.
// Optional non-consuming 16-bit peek port enabled by defining GET_BIT_PEEK_EN.
module get_bit (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    output logic        in_ready,
    input  logic        req_valid,
    input  logic [5:0]  req_size,
    input  logic        req_align,
    output logic        req_ready,
    input  logic        clear,
    output logic        out_valid,
    output logic [31:0] out_val,
    output logic [6:0]  bit_count
`ifdef GET_BIT_PEEK_EN
    ,
    output logic [15:0] peek_val,
    output logic        peek_ok
`endif
);

    logic [63:0] buf_q;
    logic [6:0]  count_q;
    logic [2:0]  pos_q;
    logic        out_valid_q;
    logic [31:0] out_val_q;

    logic [5:0]  sat_size;
    logic [2:0]  align_skip;
    logic [6:0]  consumed;
    logic [6:0]  remaining;
    logic [2:0]  in_len;
    logic        accept_in;
    logic [31:0] in_mask;
    logic [63:0] fill;
    logic [63:0] buf_next;
    logic [6:0]  count_next;
    logic [31:0] field;

    assign sat_size   = (req_size > 6'd32) ? 6'd32 : req_size;
    assign align_skip = 3'd0 - pos_q;
    assign in_ready   = (count_q <= 7'd32);
    assign req_ready  = req_valid && (req_align ? (count_q >= {4'd0, align_skip})
                                                : (count_q >= {1'b0, sat_size}));

    // Byte counts above 4 are clamped so a fill can never push the buffer past 64 bits.
    assign in_len    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign accept_in = in_valid && in_ready && (in_len != 3'd0);
    assign in_mask   = ~(32'hFFFF_FFFF >> {in_len, 3'b000});

    always_comb begin
        consumed = 7'd0;
        if (req_ready)
            consumed = req_align ? {4'd0, align_skip} : {1'b0, sat_size};
    end

    // Bits past count_q are kept zero, so new bytes can be OR-ed in right after the survivors.
    assign remaining  = count_q - consumed;
    assign fill       = {in_data & in_mask, 32'h0} >> remaining;
    assign buf_next   = (buf_q << consumed) | (accept_in ? fill : 64'h0);
    assign count_next = remaining + (accept_in ? {1'b0, in_len, 3'b000} : 7'd0);
    assign field      = (sat_size == 6'd0) ? 32'h0 : (buf_q[63:32] >> (6'd32 - sat_size));

    always_ff @(posedge clock) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            buf_q       <= 64'h0;
            count_q     <= 7'd0;
            pos_q       <= 3'd0;
            out_valid_q <= 1'b0;
            out_val_q   <= 32'h0;
        end else if (clear) begin
            buf_q       <= 64'h0;
            count_q     <= 7'd0;
            pos_q       <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_next;
            count_q     <= count_next;
            pos_q       <= pos_q + consumed[2:0];
            out_valid_q <= req_ready && !req_align;
            if (req_ready && !req_align)
                out_val_q <= field;
        end
    end

    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign bit_count = count_q;

`ifdef GET_BIT_PEEK_EN
    assign peek_val = buf_q[63:48];
    assign peek_ok  = (count_q >= 7'd16);
`endif

endmodule

// File: tb/tb_get_bit.sv
// Self-checking bench for get_bit: scoreboarded field results plus inline state checks.
// Define GET_BIT_PEEK_EN to also exercise the peek port.
module tb_get_bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_bytes;
    logic        in_ready;
    logic        req_valid;
    logic [5:0]  req_size;
    logic        req_align;
    logic        req_ready;
    logic        clear;
    logic        out_valid;
    logic [31:0] out_val;
    logic [6:0]  bit_count;
`ifdef GET_BIT_PEEK_EN
    logic [15:0] peek_val;
    logic        peek_ok;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    get_bit dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_ready  (in_ready),
        .req_valid (req_valid),
        .req_size  (req_size),
        .req_align (req_align),
        .req_ready (req_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_val   (out_val),
        .bit_count (bit_count)
`ifdef GET_BIT_PEEK_EN
        ,
        .peek_val  (peek_val),
        .peek_ok   (peek_ok)
`endif
    );

    always #5 clock = ~clock;

    // Scoreboard: every output pulse must match the oldest outstanding expected field.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got out_val=%h, required no out_valid", out_val);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_val !== e) begin
                    n_fail++;
                    $display("FAIL out_val: got %h, required %h", out_val, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        in_valid = 0; in_data = '0; in_bytes = '0;
        req_valid = 0; req_size = '0; req_align = 0; clear = 0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [2:0] nb);
        int n = 0;
        in_valid = 1; in_data = d; in_bytes = nb;
        @(negedge clock);
        while (in_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid = 0;
    endtask

    task automatic request(input logic [5:0] sz, input logic [31:0] expv);
        int n = 0;
        req_valid = 1; req_size = sz; req_align = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_timeout: req_ready=%b, required 1 (size %0d)", req_ready, sz);
        end else
            exp_q.push_back(expv);
        tick();
        req_valid = 0;
    endtask

    task automatic do_align();
        int n = 0;
        req_valid = 1; req_align = 1;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL align_timeout: req_ready=%b, required 1", req_ready);
        end
        tick();
        req_valid = 0; req_align = 0;
    endtask

    task automatic expect_count(input string name, input logic [6:0] c);
        @(negedge clock);
        n_checks++;
        if (bit_count !== c) begin
            n_fail++;
            $display("FAIL %s: bit_count=%0d, required %0d", name, bit_count, c);
        end
        tick();
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        req_valid = 1; req_size = 6'd1;
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd0 || in_ready !== 1'b1 || req_ready !== 1'b0 ||
            out_valid !== 1'b0 || out_val !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d in_ready=%b req_ready=%b out_valid=%b out_val=%h, required 0/1/0/0/0",
                     bit_count, in_ready, req_ready, out_valid, out_val);
        end
        tick();
        req_valid = 0;
    endtask

    task automatic test_nibbles();
        do_clear();
        push_word(32'hA5C3_0000, 3'd2);
        request(6'd4, 32'hA);
        request(6'd4, 32'h5);
        request(6'd8, 32'hC3);
        expect_count("nibbles_end_count", 7'd0);
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || out_val !== 32'hC3) begin
            n_fail++;
            $display("FAIL out_val_hold: out_valid=%b out_val=%h, required 0/000000c3", out_valid, out_val);
        end
        tick();
    endtask

    task automatic test_full();
        do_clear();
        push_word(32'h1234_5678, 3'd4);
        push_word(32'h9ABC_DEF0, 3'd4);
        in_valid = 1; in_data = 32'hFFFF_FFFF; in_bytes = 3'd4;
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd64 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_backpressure: cnt=%0d in_ready=%b, required 64/0", bit_count, in_ready);
        end
        tick();
        in_valid = 0;
        expect_count("full_no_overfill", 7'd64);
        request(6'd32, 32'h1234_5678);
        request(6'd32, 32'h9ABC_DEF0);
        expect_count("full_end_count", 7'd0);
    endtask

    task automatic test_align();
        do_clear();
        push_word(32'hFF00_0000, 3'd1);
        request(6'd3, 32'h7);
        do_align();
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd0) begin
            n_fail++;
            $display("FAIL align_count: bit_count=%0d, required 0", bit_count);
        end
        tick();
        request(6'd0, 32'h0);
        expect_count("zero_size_count", 7'd0);
    endtask

    task automatic test_stall();
        do_clear();
        push_word(32'hAB00_0000, 3'd1);
        req_valid = 1; req_size = 6'd12;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b0 || bit_count !== 7'd8) begin
            n_fail++;
            $display("FAIL stall_1: req_ready=%b cnt=%0d, required 0/8", req_ready, bit_count);
        end
        tick();
        in_valid = 1; in_data = 32'hCD00_0000; in_bytes = 3'd1;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_2: req_ready=%b, required 0", req_ready);
        end
        tick();
        in_data = 32'hEF00_0000;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1 || bit_count !== 7'd16) begin
            n_fail++;
            $display("FAIL stall_release: req_ready=%b cnt=%0d, required 1/16", req_ready, bit_count);
        end else
            exp_q.push_back(32'hABC);
        tick();
        in_valid = 0;
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd12 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_consume: cnt=%0d req_ready=%b, required 12/1", bit_count, req_ready);
        end else
            exp_q.push_back(32'hDEF);
        tick();
        req_valid = 0;
        expect_count("stall_end_count", 7'd0);
    endtask

    task automatic test_clear();
        do_clear();
        push_word(32'h1122_3344, 3'd4);
        push_word(32'h5500_0000, 3'd1);
        expect_count("clear_fill_count", 7'd40);
        clear = 1; in_valid = 1; in_data = 32'hFFFF_FFFF; in_bytes = 3'd4;
        req_valid = 1; req_size = 6'd8;
        tick();
        idle();
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_state: cnt=%0d in_ready=%b out_valid=%b, required 0/1/0",
                     bit_count, in_ready, out_valid);
        end
        tick();
        push_word(32'h1122_3344, 3'd4);
        push_word(32'h5500_0000, 3'd1);
        reset = 1; clear = 1; req_valid = 1; req_size = 6'd8;
        tick();
        reset = 0;
        idle();
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset: cnt=%0d in_ready=%b out_valid=%b out_val=%h, required 0/1/0/0",
                     bit_count, in_ready, out_valid, out_val);
        end
        tick();
        push_word(32'hDEAD_BEEF, 3'd4);
        push_word(32'h0100_0000, 3'd1);
        request(6'd40, 32'hDEAD_BEEF);
        expect_count("saturate_count", 7'd8);
        request(6'd8, 32'h01);
    endtask

    task automatic test_back_to_back();
        do_clear();
        push_word(32'h8C3E_1234, 3'd4);
        request(6'd1, 32'h1);
        request(6'd3, 32'h0);
        request(6'd5, 32'h18);
        request(6'd7, 32'h3E);
        request(6'd16, 32'h1234);
        do_align();
        expect_count("b2b_end_count", 7'd0);
    endtask

`ifdef GET_BIT_PEEK_EN
    task automatic test_peek();
        do_clear();
        push_word(32'hBEEF_0000, 3'd2);
        @(negedge clock);
        n_checks++;
        if (peek_val !== 16'hBEEF || peek_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL peek_16: peek_val=%h peek_ok=%b, required beef/1", peek_val, peek_ok);
        end
        tick();
        request(6'd1, 32'h1);
        @(negedge clock);
        n_checks++;
        if (bit_count !== 7'd15 || peek_ok !== 1'b0 || peek_val !== 16'h7DDE) begin
            n_fail++;
            $display("FAIL peek_15: cnt=%0d peek_ok=%b peek_val=%h, required 15/0/7dde",
                     bit_count, peek_ok, peek_val);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_nibbles();
        test_full();
        test_align();
        test_stall();
        test_clear();
        test_back_to_back();
`ifdef GET_BIT_PEEK_EN
        test_peek();
`endif
        tick(); tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
